fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have one clock and one reset; reset is synchronous and active-high, sampled on the rising edge of clk.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  decode stage cannot accept a new instruction; hold outputs.
REQ-005 br_taken  in  1  branch resolved taken this cycle (PCSrc); redirect fetch.
REQ-006 br_target  in  32  branch destination address.
REQ-007 imem_req  out  1  fetch request; imem_addr valid while high.
REQ-008 imem_addr  out  32  word address to instruction memory (current PC).
REQ-009 imem_ack  in  1  memory ready; a transfer occurs in any cycle with imem_req and imem_ack both high.
REQ-010 imem_rdata  in  32  instruction word, valid in the transfer cycle.
REQ-011 instr  out  32  registered instruction for decode.
REQ-012 instr_valid  out  1  instr holds a live instruction.
REQ-013 instr_pc  out  32  address of instr; pc_plus8  out  32  instr_pc + 8 (ARM PC read value).
REQ-014 cond  out  4  instr[31:28]; op  out  2  instr[27:26]; funct5  out  1  instr[25]; cmd  out  4  instr[24:21]; funct0  out  1  instr[20]; all combinational from instr.
REQ-015 fetch_count  out  16  number of instructions delivered since reset, saturating.

Function
REQ-016 FSM states BOOT, RUN, FLUSH; encoding is free.
REQ-017 BOOT: imem_req=0; next state RUN unconditionally (one idle cycle after reset).
REQ-018 RUN: imem_req = !(instr_valid && stall); imem_addr = pc.
REQ-019 Transfer in RUN with br_taken=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, fetch_count+=1 (saturate at 0xFFFF).
REQ-020 RUN, no transfer, instr_valid && !stall: instr_valid<=0 (instruction consumed, bubble).
REQ-021 RUN, instr_valid && stall: instr, instr_pc, instr_valid, pc unchanged; imem_req=0.
REQ-022 br_taken=1 in any state except BOOT: pc<={br_target[31:2],2'b00}, instr_valid<=0, any same-cycle transfer discarded (no count increment), next state FLUSH; br_taken overrides stall.
REQ-023 br_taken=1 in BOOT: pc redirected as REQ-022, next state FLUSH.
REQ-024 FLUSH: imem_req=0, instr_valid stays 0 (one-cycle branch penalty); next state RUN; a second br_taken in FLUSH re-redirects pc and stays in FLUSH.
REQ-025 pc+4 and instr_pc+8 wrap modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-026 imem_addr[1:0] SHALL always be 2'b00.
REQ-027 Latency: instruction transferred in cycle N appears on instr with instr_valid=1 in cycle N+1.

Reset
REQ-028 On reset: pc=0x00000000, state=BOOT, instr=0x00000000, instr_pc=0x00000000, instr_valid=0, fetch_count=0; during the reset cycle imem_req=0.
REQ-029 Reset asserted mid-operation SHALL override br_taken, stall and any transfer in that cycle.

Verification
REQ-030 Reset, imem_ack=1 constant, stall=0 -> cycle 1 req=0 (BOOT); cycle 2 req=1 addr=0x0; cycle 3 instr_valid=1, instr_pc=0x0, addr=0x4; fetch_count increments each cycle.
REQ-031 stall=1 for 3 cycles while instr_valid=1, instr=0xE3A01005 -> imem_req=0, instr/instr_pc/pc frozen; stall release -> next fetch at prior pc, no skip or duplicate.
REQ-032 br_taken=1, br_target=0x00000103, same cycle as transfer -> data discarded, instr_valid=0 for 2 cycles, next imem_addr=0x00000100, fetch_count unchanged that cycle.
REQ-033 imem_ack=0 for 4 cycles in RUN -> imem_req held 1, imem_addr stable, instr_valid drops to 0 after consumption.
REQ-034 pc=0xFFFFFFFC transfer -> next imem_addr=0x00000000; instr_pc=0xFFFFFFFC gives pc_plus8=0x00000004.
REQ-035 instr=0xE5912000 (LDR) -> cond=0xE, op=2'b01, funct5=0, cmd=4'b1100, funct0=1.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/acknowledge bus
// imem_req/imem_addr : fetch side -> memory (address valid while req high)
// imem_ack/imem_rdata: memory -> fetch side (transfer when req && ack)
// master = fetch unit, slave = instruction memory
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with branch redirect, decode stall and one-cycle branch flush
// clk, reset          : clock, synchronous active-high reset
// stall               : decode cannot accept, hold the current instruction
// br_taken, br_target : taken-branch redirect
// imem                : instruction memory bus (master)
// instr, instr_valid, instr_pc, pc_plus8 : registered instruction to decode
// cond, op, funct5, cmd, funct0          : field split of instr
// fetch_count         : saturating count of delivered instructions
module fetch_unit (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         br_taken,
   input  logic [31:0]  br_target,
   fetch_unit_if.master imem,
   output logic [31:0]  instr,
   output logic         instr_valid,
   output logic [31:0]  instr_pc,
   output logic [31:0]  pc_plus8,
   output logic [3:0]   cond,
   output logic [1:0]   op,
   output logic         funct5,
   output logic [3:0]   cmd,
   output logic         funct0,
   output logic [15:0]  fetch_count
);
   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
   state_t state, state_next;
   logic [31:0] pc;
   logic xfer;
   always_ff @(posedge clk)
      if (reset) state <= BOOT;
      else state <= state_next;
   // every state falls through to RUN unless a branch forces a flush cycle
   always_comb begin
      state_next = br_taken ? FLUSH : RUN;
      imem.imem_req = !reset && state == RUN && !(instr_valid && stall);
      imem.imem_addr = pc;
   end
   assign xfer = imem.imem_req && imem.imem_ack;
   // pc low bits are forced to zero on redirect and stay zero through +4
   always_ff @(posedge clk)
      if (reset) begin
         pc <= '0;
         instr <= '0;
         instr_pc <= '0;
         instr_valid <= 1'b0;
         fetch_count <= '0;
      end else if (br_taken) begin
         pc <= {br_target[31:2], 2'b00};
         instr_valid <= 1'b0;
      end else if (xfer) begin
         instr <= imem.imem_rdata;
         instr_pc <= pc;
         instr_valid <= 1'b1;
         pc <= pc + 32'd4;
         fetch_count <= fetch_count + {15'd0, fetch_count != 16'hFFFF};
      end else if (instr_valid && !stall) begin
         instr_valid <= 1'b0;
      end
   assign pc_plus8 = instr_pc + 32'd8;
   assign {cond, op, funct5, cmd, funct0} = instr[31:20];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset, stall, br_taken;
   logic [31:0] br_target;
   logic [31:0] instr, instr_pc, pc_plus8;
   logic        instr_valid, funct5, funct0;
   logic [3:0]  cond, cmd;
   logic [1:0]  op;
   logic [15:0] fetch_count;
   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];
   logic [64:0] obs_q[$];
   logic xfer_q = 1'b0;
   fetch_unit_if bus();
   fetch_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
      .imem(bus), .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
      .pc_plus8(pc_plus8), .cond(cond), .op(op), .funct5(funct5), .cmd(cmd),
      .funct0(funct0), .fetch_count(fetch_count)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a == 32'h8 ? 32'hE3A01005 : a == 32'hC ? 32'hE5912000 : a ^ 32'hC0DE0000 ^ {a[15:0], a[31:16]};
   endfunction
   assign bus.imem_rdata = mem(bus.imem_addr);
   always @(posedge clk) xfer_q <= bus.imem_req && bus.imem_ack && !br_taken && !reset;
   always @(negedge clk) if (xfer_q) obs_q.push_back({instr_valid, instr_pc, instr});
   task automatic test_reset();
      logic [31:0] e;
      logic [64:0] o;
      reset = 1; stall = 0; br_taken = 0; br_target = 0; bus.imem_ack = 1;
      repeat (3) @(negedge clk);
      tests++; if ({bus.imem_req, instr_valid, instr, instr_pc, fetch_count, bus.imem_addr} !== 114'd0) begin fails++; $display("FAIL rst_state got %h want 0", {bus.imem_req, instr_valid, instr, instr_pc, fetch_count, bus.imem_addr}); end
      reset = 0; #1;
      tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL boot_req got %b want 0", bus.imem_req); end
      @(negedge clk);
      tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin fails++; $display("FAIL run_first_req got %h want %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h0}); end
      exp_q.push_back(32'h0);
      @(negedge clk);
      tests++; if ({instr_valid, instr_pc, bus.imem_addr, fetch_count} !== {1'b1, 32'h0, 32'h4, 16'd1}) begin fails++; $display("FAIL first_deliver got %h want %h", {instr_valid, instr_pc, bus.imem_addr, fetch_count}, {1'b1, 32'h0, 32'h4, 16'd1}); end
      exp_q.push_back(32'h4);
      @(negedge clk);
      tests++; if ({instr_pc, fetch_count} !== {32'h4, 16'd2}) begin fails++; $display("FAIL second_deliver got %h want %h", {instr_pc, fetch_count}, {32'h4, 16'd2}); end
      bus.imem_ack = 0;
      @(negedge clk); #1;
      tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL reset_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
         if (o !== {1'b1, e, mem(e)}) begin fails++; $display("FAIL reset_sb got %h want %h", o, {1'b1, e, mem(e)}); end
      end
      exp_q.delete(); obs_q.delete();
   endtask
   task automatic test_stall();
      logic [31:0] e;
      logic [64:0] o;
      bus.imem_ack = 1; exp_q.push_back(32'h8);
      @(negedge clk);
      stall = 1;
      repeat (3) begin
         @(negedge clk);
         tests++; if ({bus.imem_req, instr_valid, instr, instr_pc, bus.imem_addr} !== {1'b0, 1'b1, 32'hE3A01005, 32'h8, 32'hC}) begin fails++; $display("FAIL stall_hold got %h want %h", {bus.imem_req, instr_valid, instr, instr_pc, bus.imem_addr}, {1'b0, 1'b1, 32'hE3A01005, 32'h8, 32'hC}); end
      end
      stall = 0; exp_q.push_back(32'hC);
      @(negedge clk);
      tests++; if ({cond, op, funct5, cmd, funct0} !== {4'hE, 2'b01, 1'b0, 4'b1100, 1'b1}) begin fails++; $display("FAIL ldr_decode got %h want %h", {cond, op, funct5, cmd, funct0}, {4'hE, 2'b01, 1'b0, 4'b1100, 1'b1}); end
      tests++; if ({instr_pc, fetch_count} !== {32'hC, 16'd4}) begin fails++; $display("FAIL stall_release got %h want %h", {instr_pc, fetch_count}, {32'hC, 16'd4}); end
      bus.imem_ack = 0;
      @(negedge clk); #1;
      tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL stall_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
         if (o !== {1'b1, e, mem(e)}) begin fails++; $display("FAIL stall_sb got %h want %h", o, {1'b1, e, mem(e)}); end
      end
      exp_q.delete(); obs_q.delete();
   endtask
   task automatic test_ack_wait();
      logic [31:0] e;
      logic [64:0] o;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL consumed_valid got %b want 0", instr_valid); end
      repeat (4) begin
         @(negedge clk);
         tests++; if ({bus.imem_req, bus.imem_addr, instr_valid} !== {1'b1, 32'h10, 1'b0}) begin fails++; $display("FAIL ack_wait got %h want %h", {bus.imem_req, bus.imem_addr, instr_valid}, {1'b1, 32'h10, 1'b0}); end
      end
      bus.imem_ack = 1; exp_q.push_back(32'h10);
      @(negedge clk);
      tests++; if ({instr_valid, instr_pc, fetch_count} !== {1'b1, 32'h10, 16'd5}) begin fails++; $display("FAIL ack_deliver got %h want %h", {instr_valid, instr_pc, fetch_count}, {1'b1, 32'h10, 16'd5}); end
      bus.imem_ack = 0;
      @(negedge clk); #1;
      tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL ack_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
         if (o !== {1'b1, e, mem(e)}) begin fails++; $display("FAIL ack_sb got %h want %h", o, {1'b1, e, mem(e)}); end
      end
      exp_q.delete(); obs_q.delete();
   endtask
   task automatic test_branch();
      logic [31:0] e;
      logic [64:0] o;
      bus.imem_ack = 1; br_taken = 1; br_target = 32'h103;
      @(negedge clk);
      br_taken = 0;
      tests++; if ({instr_valid, bus.imem_req, fetch_count} !== {1'b0, 1'b0, 16'd5}) begin fails++; $display("FAIL br_flush got %h want %h", {instr_valid, bus.imem_req, fetch_count}, {1'b0, 1'b0, 16'd5}); end
      @(negedge clk);
      tests++; if ({instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h100}) begin fails++; $display("FAIL br_target_addr got %h want %h", {instr_valid, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, 32'h100}); end
      exp_q.push_back(32'h100);
      @(negedge clk);
      tests++; if ({instr_valid, instr_pc, pc_plus8, fetch_count} !== {1'b1, 32'h100, 32'h108, 16'd6}) begin fails++; $display("FAIL br_deliver got %h want %h", {instr_valid, instr_pc, pc_plus8, fetch_count}, {1'b1, 32'h100, 32'h108, 16'd6}); end
      bus.imem_ack = 0;
      @(negedge clk); #1;
      tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL br_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
         if (o !== {1'b1, e, mem(e)}) begin fails++; $display("FAIL br_sb got %h want %h", o, {1'b1, e, mem(e)}); end
      end
      exp_q.delete(); obs_q.delete();
   endtask
   task automatic test_branch_stall();
      logic [31:0] e;
      logic [64:0] o;
      bus.imem_ack = 1; exp_q.push_back(32'h104);
      @(negedge clk);
      stall = 1;
      @(negedge clk);
      tests++; if ({instr_valid, bus.imem_req, instr_pc} !== {1'b1, 1'b0, 32'h104}) begin fails++; $display("FAIL bs_hold got %h want %h", {instr_valid, bus.imem_req, instr_pc}, {1'b1, 1'b0, 32'h104}); end
      br_taken = 1; br_target = 32'h200;
      @(negedge clk);
      tests++; if ({instr_valid, bus.imem_req} !== 2'b00) begin fails++; $display("FAIL bs_override got %b want 00", {instr_valid, bus.imem_req}); end
      br_target = 32'h300;
      @(negedge clk);
      tests++; if ({instr_valid, bus.imem_req} !== 2'b00) begin fails++; $display("FAIL bs_reflush got %b want 00", {instr_valid, bus.imem_req}); end
      br_taken = 0; stall = 0;
      @(negedge clk);
      tests++; if ({bus.imem_req, bus.imem_addr, fetch_count} !== {1'b1, 32'h300, 16'd7}) begin fails++; $display("FAIL bs_redirect got %h want %h", {bus.imem_req, bus.imem_addr, fetch_count}, {1'b1, 32'h300, 16'd7}); end
      bus.imem_ack = 0;
      @(negedge clk); #1;
      tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL bs_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
         if (o !== {1'b1, e, mem(e)}) begin fails++; $display("FAIL bs_sb got %h want %h", o, {1'b1, e, mem(e)}); end
      end
      exp_q.delete(); obs_q.delete();
   endtask
   task automatic test_wrap();
      logic [31:0] e;
      logic [64:0] o;
      br_taken = 1; br_target = 32'hFFFFFFFF;
      @(negedge clk);
      br_taken = 0;
      @(negedge clk);
      tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hFFFFFFFC}) begin fails++; $display("FAIL wrap_addr got %h want %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'hFFFFFFFC}); end
      bus.imem_ack = 1; exp_q.push_back(32'hFFFFFFFC);
      @(negedge clk);
      tests++; if ({bus.imem_addr, instr_pc, pc_plus8} !== {32'h0, 32'hFFFFFFFC, 32'h4}) begin fails++; $display("FAIL wrap_pc got %h want %h", {bus.imem_addr, instr_pc, pc_plus8}, {32'h0, 32'hFFFFFFFC, 32'h4}); end
      exp_q.push_back(32'h0);
      @(negedge clk);
      tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL wrap_next got %h want 0", instr_pc); end
      bus.imem_ack = 0;
      @(negedge clk); #1;
      tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL wrap_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
         if (o !== {1'b1, e, mem(e)}) begin fails++; $display("FAIL wrap_sb got %h want %h", o, {1'b1, e, mem(e)}); end
      end
      exp_q.delete(); obs_q.delete();
   endtask
   task automatic test_reset_override();
      logic [31:0] e;
      logic [64:0] o;
      bus.imem_ack = 1; exp_q.push_back(32'h4);
      @(negedge clk);
      tests++; if ({instr_valid, instr_pc} !== {1'b1, 32'h4}) begin fails++; $display("FAIL ro_pre got %h want %h", {instr_valid, instr_pc}, {1'b1, 32'h4}); end
      reset = 1; br_taken = 1; br_target = 32'h500; stall = 1; #1;
      tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL ro_req got %b want 0", bus.imem_req); end
      @(negedge clk);
      tests++; if ({bus.imem_req, instr_valid, instr, instr_pc, fetch_count, bus.imem_addr} !== 114'd0) begin fails++; $display("FAIL ro_state got %h want 0", {bus.imem_req, instr_valid, instr, instr_pc, fetch_count, bus.imem_addr}); end
      reset = 0; br_taken = 0; stall = 0; #1;
      tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL ro_boot got %b want 0", bus.imem_req); end
      @(negedge clk);
      tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin fails++; $display("FAIL ro_run got %h want %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h0}); end
      bus.imem_ack = 0;
      @(negedge clk); #1;
      tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL ro_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
         if (o !== {1'b1, e, mem(e)}) begin fails++; $display("FAIL ro_sb got %h want %h", o, {1'b1, e, mem(e)}); end
      end
      exp_q.delete(); obs_q.delete();
   endtask
   initial begin
      test_reset();
      test_stall();
      test_ack_wait();
      test_branch();
      test_branch_stall();
      test_wrap();
      test_reset_override();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
